// File: rtl/flit_pkg.sv
// Shared flit and lane definitions for the virtual-channel link
// (vc_allocator upstream, vc_input_buffer downstream).
package flit_pkg;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } lane_state_e;

    // Type field position, counted down from the flit MSB.
    localparam int FLIT_TYPE_MSB = 0;
    localparam int FLIT_TYPE_LSB = 1;

    localparam int CREDIT_VC_W = 4;

    typedef struct packed {
        logic                   valid;
        logic [CREDIT_VC_W-1:0] vc;
    } credit_t;

    // Callers pass din[FLIT_SIZE-1-FLIT_TYPE_MSB : FLIT_SIZE-1-FLIT_TYPE_LSB].
    function automatic flit_type_e flit_type_of(input logic [1:0] type_field);
        return flit_type_e'(type_field);
    endfunction

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// Single lane FIFO with first-word fall-through read data and a
// modulo-DEPTH pointer wrap (DEPTH need not be a power of two).
module vc_lane_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Input port of the VC link: per-lane FIFOs, per-lane packet FSM,
// credit return and sticky error flags.
//
// state | meaning
// IDLE  | lane free for allocation, expects HEAD or HEAD_TAIL
// RECV  | packet open, expects BODY or TAIL
// DRAIN | tail stored, lane released once its FIFO empties
module vc_input_buffer
    import flit_pkg::*;
#(
    parameter  int LANES_PER_CHANNEL = 2,
    parameter  int VC_DEPTH          = 5,
    parameter  int FLIT_SIZE         = 32,
    localparam int VCW = (LANES_PER_CHANNEL > 1) ? $clog2(LANES_PER_CHANNEL) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FLIT_SIZE-1:0]         din,
    input  logic                         din_valid,
    input  logic [VCW-1:0]               din_vc,
    input  logic                         rd_en,
    input  logic [VCW-1:0]               rd_vc,
    output logic [FLIT_SIZE-1:0]         dout,
    output logic [LANES_PER_CHANNEL-1:0] lane_nonempty,
    output logic [LANES_PER_CHANNEL-1:0] lane_idle,
    output logic                         credit_valid,
    output logic [VCW-1:0]               credit_vc,
    output logic                         overflow_err,
    output logic                         protocol_err
);

    localparam int L  = LANES_PER_CHANNEL;
    localparam int CW = $clog2(VC_DEPTH + 1);

    logic [FLIT_SIZE-1:0] rd_data [L];
    logic [CW-1:0]        count   [L];
    logic [L-1:0]         full, empty;
    logic [L-1:0]         wr_sel, wr_acc, rd_acc, proto_hit;
    logic                 ovf_hit;
    flit_type_e           din_type;
    lane_state_e          state_q [L];
    lane_state_e          state_d [L];

    logic                 credit_valid_q;
    logic [VCW-1:0]       credit_vc_q;
    logic                 overflow_q, protocol_q;

    assign din_type = flit_type_of(din[FLIT_SIZE-1-FLIT_TYPE_MSB : FLIT_SIZE-1-FLIT_TYPE_LSB]);

    always_comb begin
        wr_sel = '0;
        wr_acc = '0;
        rd_acc = '0;
        for (int i = 0; i < L; i++) begin
            wr_sel[i] = din_valid && (din_vc == VCW'(i));
            wr_acc[i] = wr_sel[i] && !full[i];
            rd_acc[i] = rd_en && (rd_vc == VCW'(i)) && !empty[i];
        end
        ovf_hit = |(wr_sel & full);
    end

    for (genvar g = 0; g < L; g++) begin : g_lane
        vc_lane_fifo #(
            .DEPTH (VC_DEPTH),
            .WIDTH (FLIT_SIZE)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_acc[g]),
            .wr_data (din),
            .rd_en   (rd_acc[g]),
            .rd_data (rd_data[g]),
            .count   (count[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            if (!reset) begin
                state_q[i] <= IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < L; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (wr_acc[i] && din_type == HEAD) begin
                        state_d[i] = RECV;
                    end else if (wr_acc[i] && din_type == HEAD_TAIL) begin
                        state_d[i] = DRAIN;
                    end
                end
                RECV: begin
                    if (wr_acc[i] && din_type == TAIL) begin
                        state_d[i] = DRAIN;
                    end
                end
                DRAIN: begin
                    // Last flit leaving with nothing arriving empties the lane.
                    if (rd_acc[i] && !wr_acc[i] && count[i] == CW'(1)) begin
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        proto_hit = '0;
        lane_idle = '0;
        for (int i = 0; i < L; i++) begin
            lane_idle[i] = (state_q[i] == IDLE);
            case (state_q[i])
                IDLE:    proto_hit[i] = wr_acc[i] && (din_type == BODY || din_type == TAIL);
                RECV:    proto_hit[i] = wr_acc[i] && (din_type == HEAD || din_type == HEAD_TAIL);
                DRAIN:   proto_hit[i] = wr_acc[i];
                default: proto_hit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            overflow_q     <= 1'b0;
            protocol_q     <= 1'b0;
        end else begin
            credit_valid_q <= |rd_acc;
            if (|rd_acc) begin
                credit_vc_q <= rd_vc;
            end
            overflow_q <= overflow_q | ovf_hit;
            protocol_q <= protocol_q | (|proto_hit);
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < L; i++) begin
            if (rd_vc == VCW'(i)) begin
                dout = rd_data[i];
            end
        end
    end

    assign lane_nonempty = ~empty;
    assign credit_valid  = credit_valid_q;
    assign credit_vc     = credit_vc_q;
    assign overflow_err  = overflow_q;
    assign protocol_err  = protocol_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_vc_input_buffer;

    localparam int L = 2;
    localparam int D = 5;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_vc = 1'b0;
    logic         rd_en = 1'b0;
    logic         rd_vc = 1'b0;
    logic [W-1:0] dout;
    logic [L-1:0] lane_nonempty;
    logic [L-1:0] lane_idle;
    logic         credit_valid;
    logic         credit_vc;
    logic         overflow_err;
    logic         protocol_err;

    always #5 clk = ~clk;

    vc_input_buffer #(
        .LANES_PER_CHANNEL (L),
        .VC_DEPTH          (D),
        .FLIT_SIZE         (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid),
        .din_vc        (din_vc),
        .rd_en         (rd_en),
        .rd_vc         (rd_vc),
        .dout          (dout),
        .lane_nonempty (lane_nonempty),
        .lane_idle     (lane_idle),
        .credit_valid  (credit_valid),
        .credit_vc     (credit_vc),
        .overflow_err  (overflow_err),
        .protocol_err  (protocol_err)
    );

    // Reference model: one queue per lane plus packet phase
    // (0 = free, 1 = packet open, 2 = tail stored).
    logic [W-1:0] mq [L][$];
    int           mst [L];
    bit           m_ovf, m_perr, m_cv;
    int           m_cvc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            mq[i].delete();
            mst[i] = 0;
        end
        m_ovf = 0;
        m_perr = 0;
        m_cv = 0;
        m_cvc = 0;
    endtask

    task automatic cyc(input bit wv, input logic [W-1:0] d, input int wvc,
                       input bit re, input int rvc);
        bit rok, wok;
        int ty;
        din_valid = wv;
        din       = d;
        din_vc    = wvc[0];
        rd_en     = re;
        rd_vc     = rvc[0];
        rok = re && (mq[rvc].size() > 0);
        wok = wv && (mq[wvc].size() < D);
        if (wv && !wok) m_ovf = 1;
        if (rok) void'(mq[rvc].pop_front());
        if (wok) begin
            mq[wvc].push_back(d);
            ty = int'(d[W-1:W-2]);
            if (mst[wvc] == 0) begin
                if (ty == 1) mst[wvc] = 1;
                else if (ty == 3) mst[wvc] = 2;
                else m_perr = 1;
            end else if (mst[wvc] == 1) begin
                if (ty == 2) mst[wvc] = 2;
                else if (ty != 0) m_perr = 1;
            end else begin
                m_perr = 1;
            end
        end
        for (int i = 0; i < L; i++) begin
            if (mst[i] == 2 && mq[i].size() == 0) mst[i] = 0;
        end
        m_cv = rok;
        if (rok) m_cvc = rvc;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic do_reset(input bit re);
        reset     = 1'b0;
        din_valid = 1'b0;
        rd_en     = re;
        rd_vc     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_en = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) cyc(0, '0, 0, 0, 0);
        n_checks++;
        if (lane_idle !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_lane_idle got %b want 11", lane_idle);
        end
        n_checks++;
        if (lane_nonempty !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_nonempty got %b want 00", lane_nonempty);
        end
        n_checks++;
        if (credit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_credit got %b want 0", credit_valid);
        end
        n_checks++;
        if (overflow_err !== 1'b0 || protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_errs got ovf=%b prot=%b want 0 0", overflow_err, protocol_err);
        end
    endtask

    task automatic test_packet();
        logic [W-1:0] pkt [3];
        pkt[0] = 32'h4000_0001;
        pkt[1] = 32'h0000_00A5;
        pkt[2] = 32'h8000_0003;
        cyc(1, pkt[0], 0, 0, 0);
        n_checks++;
        if (lane_idle[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_idle_after_head got %b want 0", lane_idle[0]);
        end
        cyc(1, pkt[1], 0, 0, 0);
        cyc(1, pkt[2], 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            rd_vc = 1'b0;
            #1;
            n_checks++;
            if (dout !== pkt[k]) begin
                n_fail++;
                $display("FAIL pkt_dout[%0d] got %h want %h", k, dout, pkt[k]);
            end
            cyc(0, '0, 0, 1, 0);
            n_checks++;
            if (credit_valid !== 1'b1 || credit_vc !== 1'b0) begin
                n_fail++;
                $display("FAIL pkt_credit[%0d] got v=%b vc=%b want v=1 vc=0", k, credit_valid, credit_vc);
            end
            n_checks++;
            if (lane_idle[0] !== (k == 2)) begin
                n_fail++;
                $display("FAIL pkt_idle[%0d] got %b want %b", k, lane_idle[0], (k == 2));
            end
        end
        cyc(0, '0, 0, 0, 0);
        n_checks++;
        if (credit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_credit_pulse got %b want 0", credit_valid);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] f [5];
        do_reset(1'b0);
        f[0] = 32'h4000_0010;
        for (int k = 1; k < 5; k++) f[k] = 32'h0000_0010 + W'(k);
        for (int k = 0; k < 5; k++) cyc(1, f[k], 1, 0, 0);
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early got %b want 0", overflow_err);
        end
        cyc(1, 32'h0000_00FF, 1, 0, 0);
        n_checks++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag got %b want 1", overflow_err);
        end
        // Full lane written while being read: write must still be dropped.
        rd_vc = 1'b1;
        #1;
        n_checks++;
        if (dout !== f[0]) begin
            n_fail++;
            $display("FAIL ovf_dout[0] got %h want %h", dout, f[0]);
        end
        cyc(1, 32'h0000_00EE, 1, 1, 1);
        for (int k = 1; k < 5; k++) begin
            rd_vc = 1'b1;
            #1;
            n_checks++;
            if (dout !== f[k]) begin
                n_fail++;
                $display("FAIL ovf_dout[%0d] got %h want %h", k, dout, f[k]);
            end
            cyc(0, '0, 0, 1, 1);
        end
        n_checks++;
        if (lane_nonempty[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_extra_flit got %b want 0", lane_nonempty[1]);
        end
    endtask

    task automatic test_wrap();
        int credits;
        logic [W-1:0] exp_w;
        do_reset(1'b0);
        cyc(1, 32'h4000_0100, 0, 0, 0);
        for (int k = 1; k < 4; k++) cyc(1, 32'h0000_0100 + W'(k), 0, 0, 0);
        credits = 0;
        for (int k = 0; k < 8; k++) begin
            rd_vc = 1'b0;
            #1;
            n_checks++;
            if (dout !== mq[0][0]) begin
                n_fail++;
                $display("FAIL wrap_dout[%0d] got %h want %h", k, dout, mq[0][0]);
            end
            cyc(1, 32'h0000_0200 + W'(k), 0, 1, 0);
            if (credit_valid === 1'b1) credits++;
        end
        n_checks++;
        if (credits != 8) begin
            n_fail++;
            $display("FAIL wrap_credits got %0d want 8", credits);
        end
        for (int k = 4; k < 8; k++) begin
            exp_w = 32'h0000_0200 + W'(k);
            rd_vc = 1'b0;
            #1;
            n_checks++;
            if (dout !== exp_w) begin
                n_fail++;
                $display("FAIL wrap_tail_dout[%0d] got %h want %h", k, dout, exp_w);
            end
            cyc(0, '0, 0, 1, 0);
        end
        n_checks++;
        if (lane_nonempty[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count got nonempty=%b want 0", lane_nonempty[0]);
        end
    endtask

    task automatic test_protocol();
        do_reset(1'b0);
        cyc(1, 32'h0000_0042, 1, 0, 0);
        n_checks++;
        if (protocol_err !== 1'b1 || lane_idle[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL prot_body_idle got err=%b idle1=%b want 1 1", protocol_err, lane_idle[1]);
        end
        cyc(1, 32'hC000_0007, 0, 0, 0);
        n_checks++;
        if (lane_idle[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL prot_headtail_drain got idle0=%b want 0", lane_idle[0]);
        end
        rd_vc = 1'b0;
        #1;
        n_checks++;
        if (dout !== 32'hC000_0007) begin
            n_fail++;
            $display("FAIL prot_dout got %h want c0000007", dout);
        end
        cyc(0, '0, 0, 1, 0);
        n_checks++;
        if (lane_idle !== 2'b11 || credit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL prot_release got idle=%b cv=%b want 11 1", lane_idle, credit_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset(1'b0);
        cyc(1, 32'h4000_0300, 0, 0, 0);
        cyc(1, 32'h0000_0301, 0, 0, 0);
        cyc(1, 32'h0000_0302, 0, 0, 0);
        do_reset(1'b1);
        n_checks++;
        if (lane_nonempty !== 2'b00 || lane_idle !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_state got ne=%b idle=%b want 00 11", lane_nonempty, lane_idle);
        end
        n_checks++;
        if (credit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_credit got %b want 0", credit_valid);
        end
        cyc(0, '0, 0, 0, 0);
        n_checks++;
        if (credit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_credit_late got %b want 0", credit_valid);
        end
    endtask

    task automatic test_random();
        logic [L-1:0] e_ne, e_idle;
        logic [W-1:0] d;
        bit wv, re;
        int wvc, rvc;
        do_reset(1'b0);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(149) == 0) do_reset(1'b0);
            wv  = ($urandom_range(1) == 1);
            wvc = int'($urandom_range(1));
            rvc = int'($urandom_range(1));
            re  = (n < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            d   = $urandom;
            cyc(wv, d, wvc, re, rvc);
            for (int i = 0; i < L; i++) begin
                e_ne[i]   = (mq[i].size() > 0);
                e_idle[i] = (mst[i] == 0);
            end
            n_checks++;
            if (lane_nonempty !== e_ne || lane_idle !== e_idle) begin
                n_fail++;
                $display("FAIL rand_lanes[%0d] got ne=%b idle=%b want ne=%b idle=%b",
                         n, lane_nonempty, lane_idle, e_ne, e_idle);
            end
            n_checks++;
            if (credit_valid !== m_cv || (m_cv && credit_vc !== m_cvc[0])) begin
                n_fail++;
                $display("FAIL rand_credit[%0d] got v=%b vc=%b want v=%b vc=%0d",
                         n, credit_valid, credit_vc, m_cv, m_cvc);
            end
            n_checks++;
            if (overflow_err !== m_ovf || protocol_err !== m_perr) begin
                n_fail++;
                $display("FAIL rand_errs[%0d] got ovf=%b prot=%b want %b %b",
                         n, overflow_err, protocol_err, m_ovf, m_perr);
            end
            if (mq[rvc].size() > 0) begin
                n_checks++;
                if (dout !== mq[rvc][0]) begin
                    n_fail++;
                    $display("FAIL rand_dout[%0d] got %h want %h", n, dout, mq[rvc][0]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_packet();
        test_overflow();
        test_wrap();
        test_protocol();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
Downstream end of the virtual-channel link driven by vc_allocator. It accepts flits tagged with an output VC id from the upstream router port and stores them in per-lane FIFOs. It exposes the head flit of each lane to the local switch stage and returns one credit upstream per dequeued flit. It also tracks the per-lane packet state so lanes are released for reallocation only after a tail flit has fully drained.

Parameters:
LANES_PER_CHANNEL, 2, number of virtual-channel lanes on the input port.
VC_DEPTH, 5, flit slots per lane FIFO; also the initial upstream credit count per lane.
FLIT_SIZE, 32, flit width in bits; bits [FLIT_SIZE-1:FLIT_SIZE-2] are the flit type.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0).
din  input  FLIT_SIZE  incoming flit from the upstream link.
din_valid  input  1  din and din_vc are valid this cycle.
din_vc  input  VCW  target lane, where VCW = max(1, $clog2(LANES_PER_CHANNEL)).
rd_en  input  1  dequeue the head flit of lane rd_vc.
rd_vc  input  VCW  lane selected for dequeue and for dout.
dout  output  FLIT_SIZE  head flit of lane rd_vc (first-word fall-through).
lane_nonempty  output  LANES_PER_CHANNEL  bit i = lane i holds at least one flit.
lane_idle  output  LANES_PER_CHANNEL  bit i = lane i is in state IDLE (free for allocation).
credit_valid  output  1  one credit is returned this cycle.
credit_vc  output  VCW  lane the credit belongs to.
overflow_err  output  1  sticky: a write arrived for a full lane.
protocol_err  output  1  sticky: flit type was illegal for the lane state.

Behaviour:
- Reset (reset==0 at a clk edge): all FIFOs empty, pointers and counts 0, every lane IDLE. Outputs: lane_nonempty=0, lane_idle=all 1s, credit_valid=0, credit_vc=0, overflow_err=0, protocol_err=0. dout is don't-care while the selected lane is empty. Reset mid-packet discards all stored flits and issues no credits.
- Flit types: 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL.
- Write: when din_valid is high and count[din_vc] < VC_DEPTH, din is stored at the wrptr and count increments next cycle.
  - Write to a full lane: the flit is dropped and overflow_err is set. This applies even if the same lane is dequeued in the same cycle, because credit-based upstream never sends without a credit.
- Read: when rd_en is high and lane rd_vc is nonempty, rdptr advances. A read of an empty lane is ignored and returns no credit.
- Simultaneous read and write on the same non-full lane: count is unchanged; both pointers advance.
- Pointers wrap modulo VC_DEPTH (VC_DEPTH need not be a power of 2). Count width is $clog2(VC_DEPTH+1).
- Credit: each accepted dequeue registers credit_valid=1 and credit_vc=rd_vc on the next cycle, giving 1-cycle latency. At most one credit per cycle.
- dout = mem[rd_vc][rdptr[rd_vc]], combinational from stored state; a flit written in cycle N is visible in cycle N+1.
- Per-lane FSM, driven by accepted writes and dequeues:
  - IDLE, HEAD accepted -> RECV.
  - IDLE, HEAD_TAIL accepted -> DRAIN.
  - IDLE, BODY or TAIL accepted -> protocol_err set; flit stored; state stays IDLE.
  - RECV, BODY -> RECV.
  - RECV, TAIL -> DRAIN.
  - RECV, HEAD or HEAD_TAIL -> protocol_err set; flit stored; state unchanged.
  - DRAIN: any write -> protocol_err set; flit stored.
  - DRAIN -> IDLE on the cycle count reaches 0 (a dequeue leaves the lane empty).
- lane_idle is registered state, so a lane becomes reusable one cycle after its last flit leaves.
- Sticky errors clear only on reset.

Decomposition:
- Shared package flit_pkg holds:
  - flit_type_e (BODY, HEAD, TAIL, HEAD_TAIL);
  - FLIT_TYPE_MSB/LSB offset constants;
  - the lane_state_e enum (IDLE, RECV, DRAIN);
  - a function that extracts the type from a flit of width FLIT_SIZE.
- vc_allocator consumes lane_state_e and the credit interface from the same package.
- One sub-module, vc_lane_fifo, instantiated LANES_PER_CHANNEL times. It holds storage, pointers and count, with ports wr_en, wr_data, rd_en, rd_data, count, full, empty.
- The FSM, credit register and error logic sit in the top module.

Test Plan:
- Reset, then hold reset=1 idle 3 cycles -> lane_idle=2'b11, lane_nonempty=0, credit_valid=0, both errs=0.
- HEAD(0x4000_0001), BODY, TAIL(0x8000_0003) to vc0; then rd_en vc0 x3 -> dout order 0x4000_0001, BODY, 0x8000_0003; three credit pulses with credit_vc=0, each 1 cycle after its read; lane_idle[0] goes 0 after the head and back to 1 one cycle after the last read.
- Write 5 flits (HEAD + 4 BODY) to vc1, then a 6th -> flit dropped, overflow_err=1, count stays 5; the 5 reads return the first 5 flits only.
- Fill vc0 to 4, then rd_en vc0 and write vc0 in the same cycle, repeated 8 times -> count stays 4, pointers wrap past VC_DEPTH, FIFO data order preserved, 8 credits.
- BODY to idle vc1 -> protocol_err=1, lane_idle[1] stays 1; HEAD_TAIL to vc0 -> DRAIN, and a read returns it to IDLE.
- Reset asserted with 3 flits queued in vc0 -> next cycle lane_nonempty=0, lane_idle=all 1s, no credit_valid.
